branch_redirect_ctrl: RTL

Execute-side control-flow resolver that drives the fetch stage's PC-source inputs. It takes resolved BEQ/JAL/JLR information from EX and R7 writes from WB. It registers the redirect command (select code, targets, R7 override) and the PC enable toward fetch. It also generates a multi-cycle wrong-path flush and services decode stall requests through a small state machine.

---
 rtl/branch_redirect_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// Execute-side control-flow resolver: turns resolved JAL/JLR/BEQ and WB R7 writes
// into a registered fetch redirect, a multi-cycle wrong-path flush and decode stalls.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       ex_op,
  input  logic [15:0]      ex_pc,
  input  logic [15:0]      ex_imm,
  input  logic [15:0]      ex_ra_data,
  input  logic [15:0]      ex_rb_data,
  input  logic             wb_r7_write,
  input  logic [15:0]      wb_r7_data,
  input  logic             stall_req,
  output logic [1:0]       pc_select_out,
  output logic [15:0]      pc_plus_imm_out,
  output logic [15:0]      jlr_out,
  output logic [15:0]      beq_out,
  output logic             r7_detect_out,
  output logic [15:0]      r7_data_out,
  output logic             en_pc_out,
  output logic             flush_out,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2,
    S_STALL    = 2'd3
  } state_t;

  localparam logic [1:0] OP_JAL = 2'b01;
  localparam logic [1:0] OP_JLR = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_flush_left;
  logic [1:0]       r_pc_select;
  logic [15:0]      r_pc_plus_imm;
  logic [15:0]      r_jlr;
  logic [15:0]      r_beq;
  logic             r_r7_detect;
  logic [15:0]      r_r7_data;
  logic             r_en_pc;
  logic             r_flush;
  logic [CNT_W-1:0] r_cnt;

  logic             w_taken;
  logic             w_in_flush;
  logic             w_ex_redirect;
  logic [15:0]      w_rel_target;
  logic [CNT_W-1:0] w_cnt_inc;

  // Anything in EX while the flush is active is on the wrong path.
  assign w_in_flush    = (r_state == S_REDIRECT) || (r_state == S_FLUSH);
  assign w_taken       = ex_valid && ((ex_op == OP_JAL) || (ex_op == OP_JLR) ||
                         ((ex_op == OP_BEQ) && (ex_ra_data == ex_rb_data)));
  assign w_ex_redirect = w_taken && !w_in_flush;
  assign w_rel_target  = ex_pc + ex_imm;
  assign w_cnt_inc     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_RUN;
      r_flush_left  <= '0;
      r_pc_select   <= 2'b00;
      r_pc_plus_imm <= '0;
      r_jlr         <= '0;
      r_beq         <= '0;
      r_r7_detect   <= 1'b0;
      r_r7_data     <= '0;
      r_en_pc       <= 1'b1;
      r_flush       <= 1'b0;
      r_cnt         <= '0;
    end else if (wb_r7_write) begin
      r_state      <= S_REDIRECT;
      r_flush_left <= FLUSH_INIT;
      r_pc_select  <= 2'b00;
      r_r7_detect  <= 1'b1;
      r_r7_data    <= wb_r7_data;
      r_en_pc      <= 1'b1;
      r_flush      <= 1'b1;
      r_cnt        <= w_cnt_inc;
    end else if (w_ex_redirect) begin
      r_state      <= S_REDIRECT;
      r_flush_left <= FLUSH_INIT;
      r_pc_select  <= ex_op;
      r_r7_detect  <= 1'b0;
      r_en_pc      <= 1'b1;
      r_flush      <= 1'b1;
      r_cnt        <= w_cnt_inc;
      case (ex_op)
        OP_JAL:  r_pc_plus_imm <= w_rel_target;
        OP_JLR:  r_jlr         <= ex_rb_data;
        OP_BEQ:  r_beq         <= w_rel_target;
        default: ;
      endcase
    end else if (w_in_flush) begin
      r_pc_select <= 2'b00;
      r_r7_detect <= 1'b0;
      r_en_pc     <= 1'b1;
      if (r_flush_left == 3'd0) begin
        r_state <= S_RUN;
        r_flush <= 1'b0;
      end else begin
        r_state      <= S_FLUSH;
        r_flush      <= 1'b1;
        r_flush_left <= r_flush_left - 3'd1;
      end
    end else if (stall_req) begin
      r_state     <= S_STALL;
      r_pc_select <= 2'b00;
      r_r7_detect <= 1'b0;
      r_en_pc     <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_state     <= S_RUN;
      r_pc_select <= 2'b00;
      r_r7_detect <= 1'b0;
      r_en_pc     <= 1'b1;
      r_flush     <= 1'b0;
    end
  end

  assign pc_select_out   = r_pc_select;
  assign pc_plus_imm_out = r_pc_plus_imm;
  assign jlr_out         = r_jlr;
  assign beq_out         = r_beq;
  assign r7_detect_out   = r_r7_detect;
  assign r7_data_out     = r_r7_data;
  assign en_pc_out       = r_en_pc;
  assign flush_out       = r_flush;
  assign redirect_cnt    = r_cnt;
  assign state_dbg       = r_state;

endmodule
